seq_stim_ctrl: RTL and testbench
================================

// Module: seq_stim_ctrl
// PURPOSE
//  Sequencer that drives the serial input x of the sequence-detector datapath.
//  Accepts a pattern word, shifts len bits MSB-first onto det_x (one bit/clk),
//  pads with GAP zero cycles, optionally pulses det_rst before the pattern, and
//  counts the nonzero detector codes seen on det_y. Sits between a host/stimulus
//  source and the detector; replaces hand-timed x/rst stimulus.
// PARAMETERS
//  PAT_W  8  pattern word width, max bits per pattern
//  LEN_W  4  width of pat_len (must hold PAT_W)
//  GAP    2  zero cycles on det_x after each pattern (0 allowed)
//  CNT_W  8  width of each hit counter (saturating)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  pat_valid  in   1      pattern offered
//  pat_ready  out  1      controller idle, can accept
//  pat_data   in   PAT_W  pattern bits, sent pat_data[len-1] first down to [0]
//  pat_len    in   LEN_W  bits to send; 0 or >PAT_W treated as PAT_W
//  pat_clr    in   1      pulse det_rst and clear counters before this pattern
//  det_x      out  1      serial bit to detector x
//  det_rst    out  1      1-cycle reset pulse to detector
//  det_y      in   2      detector output code
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse, pattern+gap complete
//  cnt1/2/3   out  CNT_W  count of sampled cycles with det_y==1/2/3
// BEHAVIOUR
//  - Reset (async): state=IDLE, det_x=0, det_rst=0, done=0, counters=0, busy=0.
//  - All outputs registered. pat_ready = (state==IDLE), combinational from state.
//  - Accept = pat_valid & pat_ready at edge k. Latch shreg = data << (PAT_W-len),
//    bitcnt = len. pat_valid while busy is ignored (source must hold).
//  - FSM: IDLE -> (clr ? CLEAR : SHIFT) on accept.
//    CLEAR: det_rst=1, det_x=0, counters cleared; exactly 1 cycle -> SHIFT.
//    SHIFT: det_x = shreg[PAT_W-1], shift left, bitcnt--; after len cycles ->
//      GAP (GAP>0) else DONE.
//    GAP: det_x=0 for GAP cycles -> DONE.
//    DONE: done=1, det_x=0, 1 cycle -> IDLE.
//  - Latency: no clr: first bit in cycle k+1; clr: det_rst in k+1, first bit
//    k+2. done asserted len+GAP cycles after first bit. pat_ready high again
//    the cycle after done.
//  - Counting: det_y sampled in SHIFT, GAP and DONE cycles only (covers 1-cycle
//    detector lag); code 0 ignored; counter saturates at all-ones, never wraps.
//    Counters persist across patterns unless pat_clr or rst.
//  - det_rst and det_x are never 1 in the same cycle.
//  - rst mid-pattern: immediate return to reset values; remaining bits dropped,
//    no done pulse; pat_valid ignored while rst high.
// TESTING
//  1 Reset: rst=1 then 0 -> pat_ready=1, busy=0, det_x=0, det_rst=0, cnt*=0.
//  2 data=8'h05, len=3, clr=0 -> det_x=1,0,1 in k+1..k+3, 0 in k+4..k+5, done
//    at k+6, pat_ready=1 at k+7; det_rst stays 0.
//  3 data=8'h09, len=4, clr=1 after nonzero counts -> det_rst=1 only in k+1,
//    cnt*=0 at k+2, det_x=1,0,0,1 in k+2..k+5, done k+8.
//  4 data=8'hA5, len=0 -> 8 bits 1,0,1,0,0,1,0,1; same for len=9.
//  5 Stub det_y=2'b11 constant, back-to-back len=8 patterns for >300 cycles ->
//    cnt3 reaches 255 and holds; cnt1=cnt2=0.
//  6 rst pulsed at 2nd SHIFT cycle -> det_x=0, busy=0, cnt*=0 immediately, no
//    done; next pattern after release sent in full from bit len-1.

Source files
------------

// File: rtl/seq_stim_if.sv
// Pattern handshake between a stimulus source (master) and the sequencer (slave).
interface seq_stim_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
);
    logic             pat_valid;
    logic             pat_ready;
    logic [PAT_W-1:0] pat_data;
    logic [LEN_W-1:0] pat_len;
    logic             pat_clr;

    modport master (output pat_valid, pat_data, pat_len, pat_clr, input pat_ready);
    modport slave  (input pat_valid, pat_data, pat_len, pat_clr, output pat_ready);
endinterface

// File: rtl/seq_stim_ctrl.sv
// Serialises pattern words MSB-first onto the detector x input, pads with zero
// gap cycles, optionally resets the detector first, and counts detector hits.
module seq_stim_ctrl #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_stim_if.slave        pat,
    output logic             det_x,
    output logic             det_rst,
    input  logic [1:0]       det_y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);
    localparam int GCW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [PAT_W-1:0]   shreg, shreg_nxt, aligned;
    logic [LEN_W-1:0]   bitcnt, bitcnt_nxt, len_eff;
    logic [GCW-1:0]     gcnt, gcnt_nxt;
    logic [CNT_W-1:0]   cnt_q [3];
    logic               accept, clr_cnt, sample;

    assign pat.pat_ready = (state == S_IDLE);
    assign accept        = (state == S_IDLE) && pat.pat_valid;
    assign clr_cnt       = accept && pat.pat_clr;
    assign sample        = (state == S_SHIFT) || (state == S_GAP) || (state == S_DONE);

    // Out-of-range lengths fall back to a full word.
    assign len_eff = ((pat.pat_len == '0) || (pat.pat_len > LEN_W'(PAT_W))) ?
                     LEN_W'(PAT_W) : pat.pat_len;
    assign aligned = pat.pat_data << (LEN_W'(PAT_W) - len_eff);

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        gcnt_nxt   = gcnt;
        case (state)
            S_IDLE: if (accept) begin
                shreg_nxt  = aligned;
                bitcnt_nxt = len_eff;
                state_nxt  = pat.pat_clr ? S_CLEAR : S_SHIFT;
            end
            S_CLEAR: state_nxt = S_SHIFT;
            S_SHIFT: if (bitcnt == LEN_W'(1)) begin
                state_nxt = (GAP > 0) ? S_GAP : S_DONE;
                gcnt_nxt  = GCW'(GAP - 1);
            end else begin
                shreg_nxt  = shreg << 1;
                bitcnt_nxt = bitcnt - LEN_W'(1);
            end
            S_GAP: if (gcnt == '0) state_nxt = S_DONE;
                   else            gcnt_nxt  = gcnt - GCW'(1);
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            gcnt    <= '0;
            det_x   <= 1'b0;
            det_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bitcnt  <= bitcnt_nxt;
            gcnt    <= gcnt_nxt;
            det_x   <= (state_nxt == S_SHIFT) && shreg_nxt[PAT_W-1];
            det_rst <= (state_nxt == S_CLEAR);
            busy    <= (state_nxt != S_IDLE);
            done    <= (state_nxt == S_DONE);
        end
    end

    // Saturating hit counters, one per nonzero detector code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else if (sample) begin
            for (int i = 0; i < 3; i++)
                if ((det_y == 2'(i + 1)) && (cnt_q[i] != '1))
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
    end

    assign cnt1 = cnt_q[0];
    assign cnt2 = cnt_q[1];
    assign cnt3 = cnt_q[2];
endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Directed bench for seq_stim_ctrl: latency, padding, clear, length clamp,
// counter saturation and mid-pattern reset.
module tb_seq_stim_ctrl;
    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int GAP   = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             det_x, det_rst, busy, done;
    logic [1:0]       det_y = 2'd0;
    logic [CNT_W-1:0] cnt1, cnt2, cnt3;
    int               nchk = 0;
    int               nerr = 0;

    seq_stim_if #(.PAT_W(PAT_W), .LEN_W(LEN_W)) pif ();

    seq_stim_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pat(pif.slave),
        .det_x(det_x), .det_rst(det_rst), .det_y(det_y),
        .busy(busy), .done(done), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one pattern and check its full timeline; expected bits are given MSB-first.
    task automatic run_pat(input string tag, input logic [7:0] d, input logic [3:0] l,
                           input logic c, input logic [7:0] exp, input int n);
        logic [7:0] cap = '0;
        logic       gx = 1'b0, dr = 1'b0, dn = 1'b0;
        int         t = 0;
        while (!pif.pat_ready && t < 50) begin step(); t++; end
        chk({tag, " ready"}, pif.pat_ready, 1'b1);
        pif.pat_valid = 1'b1; pif.pat_data = d; pif.pat_len = l; pif.pat_clr = c;
        step();
        pif.pat_valid = 1'b0;
        chk({tag, " busy"}, busy, 1'b1);
        if (c) begin
            chk({tag, " rstpulse"}, det_rst, 1'b1);
            chk({tag, " x_in_clr"}, det_x, 1'b0);
            step();
            chk({tag, " cntclr"}, {8'd0, cnt1, cnt2, cnt3}, 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            cap = {cap[6:0], det_x}; dr |= det_rst; dn |= done;
            step();
        end
        for (int g = 0; g < GAP; g++) begin
            gx |= det_x; dr |= det_rst; dn |= done;
            step();
        end
        chk({tag, " bits"}, cap, exp);
        chk({tag, " gap_x"}, gx, 1'b0);
        chk({tag, " rst_low"}, dr, 1'b0);
        chk({tag, " early_done"}, dn, 1'b0);
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " x_done"}, det_x, 1'b0);
        step();
        chk({tag, " ready_after"}, pif.pat_ready, 1'b1);
        chk({tag, " done_clr"}, done, 1'b0);
    endtask

    initial begin
        pif.pat_valid = 1'b0; pif.pat_data = '0; pif.pat_len = '0; pif.pat_clr = 1'b0;
        // 1: reset state
        step(); step();
        chk("rst busy", busy, 1'b0);
        chk("rst x", det_x, 1'b0);
        rst = 1'b0;
        step();
        chk("rst ready", pif.pat_ready, 1'b1);
        chk("rst busy2", busy, 1'b0);
        chk("rst detrst", det_rst, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst cnts", {8'd0, cnt1, cnt2, cnt3}, 32'd0);

        // 2: 3-bit pattern 101, code 1 counted over 3 shift + 2 gap + 1 done cycles
        det_y = 2'd1;
        run_pat("p05", 8'h05, 4'd3, 1'b0, 8'b0000_0101, 3);
        det_y = 2'd0;
        chk("p05 cnt1", cnt1, 8'd6);
        chk("p05 cnt2", cnt2, 8'd0);

        // 3: clear before 1001, code 2 counted 4+2+1 cycles after the clear
        det_y = 2'd2;
        run_pat("p09", 8'h09, 4'd4, 1'b1, 8'b0000_1001, 4);
        det_y = 2'd0;
        chk("p09 cnt1", cnt1, 8'd0);
        chk("p09 cnt2", cnt2, 8'd7);

        // 4: length 0 and 9 both clamp to 8
        run_pat("len0", 8'hA5, 4'd0, 1'b0, 8'hA5, 8);
        run_pat("len9", 8'hA5, 4'd9, 1'b0, 8'hA5, 8);

        // 5: 26 patterns x 11 counted cycles = 286 hits, must saturate at 255
        det_y = 2'd3;
        for (int p = 0; p < 26; p++)
            run_pat($sformatf("sat%0d", p), 8'h3C, 4'd8, (p == 0), 8'h3C, 8);
        det_y = 2'd0;
        chk("sat cnt3", cnt3, 8'd255);
        chk("sat cnt1", cnt1, 8'd0);
        chk("sat cnt2", cnt2, 8'd0);

        // 6: reset during the second shift cycle of F0
        det_y = 2'd1;
        pif.pat_valid = 1'b1; pif.pat_data = 8'hF0; pif.pat_len = 4'd8; pif.pat_clr = 1'b0;
        step();
        pif.pat_valid = 1'b0;
        chk("mid first", det_x, 1'b1);
        step();
        rst = 1'b1;
        #1;
        chk("mid x", det_x, 1'b0);
        chk("mid busy", busy, 1'b0);
        chk("mid cnt3", cnt3, 8'd0);
        chk("mid cnt1", cnt1, 8'd0);
        pif.pat_valid = 1'b1;
        step();
        chk("mid nodone", done, 1'b0);
        chk("mid busy2", busy, 1'b0);
        pif.pat_valid = 1'b0;
        rst = 1'b0;
        det_y = 2'd0;
        step();
        chk("mid idle", busy, 1'b0);
        run_pat("post", 8'hC3, 4'd8, 1'b0, 8'hC3, 8);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
